ps2_control_decoder: RTL and testbench

- Receive-only PS/2 keyboard front end for the Asteroids ship path.
- Synchronises PS2_CLK/PS2_DAT, deframes 11-bit PS/2 frames, and tracks E0 (extended) and F0 (break) prefixes.
- Produces level-held ship control flags (shoot, forward, rotate_right, rotate_left) consumed by the ship controller.
- Sits between the PS/2 pins and the ship controller; supersedes the inline keyboard instance.

---
 rtl/ps2_pkg.sv | 55 +++++
 rtl/ps2_control_decoder_if.sv | 9 +
 rtl/ps2_rx_frame.sv | 129 ++++++++++++
 rtl/ps2_control_decoder.sv | 129 ++++++++++++
 tb/tb_ps2_control_decoder.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 ship-control front end: receiver
// FSM states, scan codes of interest and the key-to-control mapping.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    typedef enum logic [2:0] {
        KeyNone,
        KeyShoot,
        KeyForward,
        KeyRight,
        KeyLeft
    } key_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // ct=0 selects WASD (non-extended only), ct=1 selects the extended arrow keys.
    function automatic key_e map_key(input logic ct, input logic ext, input logic [7:0] code);
        key_e k;
        k = KeyNone;
        if (!ext && code == SC_SPACE) begin
            k = KeyShoot;
        end else if (!ct && !ext) begin
            case (code)
                SC_W:    k = KeyForward;
                SC_A:    k = KeyLeft;
                SC_D:    k = KeyRight;
                default: k = KeyNone;
            endcase
        end else if (ct && ext) begin
            case (code)
                SC_UP:    k = KeyForward;
                SC_LEFT:  k = KeyLeft;
                SC_RIGHT: k = KeyRight;
                default:  k = KeyNone;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_control_decoder_if.sv
// Received-byte stream of the PS/2 decoder: good bytes and framing errors.
interface ps2_control_decoder_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    modport master (output byte_valid, output byte_data, output frame_err);
    modport slave  (input  byte_valid, input  byte_data, input  frame_err);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 receiver: pin synchronisers, falling-edge detect, 11-bit frame FSM and
// an inactivity timeout that aborts a stalled frame.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned Timeout = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam int unsigned CntW = $clog2(Timeout + 1);

    logic            clk_s1_q, clk_s2_q, clk_prev_q;
    logic            dat_s1_q, dat_s2_q;
    rx_state_e       state_q, state_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_ok_q, par_ok_d;
    logic            byte_valid_q, byte_valid_d;
    logic [7:0]      byte_data_q, byte_data_d;
    logic            frame_err_q, frame_err_d;
    logic [CntW-1:0] tmo_q, tmo_d;
    logic            fall;
    logic            dat;

    assign fall = clk_prev_q & ~clk_s2_q;
    assign dat  = dat_s2_q;

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        par_ok_d     = par_ok_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        frame_err_d  = 1'b0;
        tmo_d        = '0;

        if (state_q != StIdle) begin
            tmo_d = fall ? '0 : tmo_q + CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (fall && !dat) begin
                    state_d  = StData;
                    bitcnt_d = 3'd0;
                end
            end
            StData: begin
                if (fall) begin
                    shreg_d  = {dat, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (fall) begin
                    par_ok_d = (^shreg_q) ^ dat;
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (fall) begin
                    state_d = StIdle;
                    if (dat && par_ok_q) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = shreg_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A stalled frame is dropped; the counter only runs outside IDLE.
        if (state_q != StIdle && !fall && tmo_q == CntW'(Timeout - 1)) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
            tmo_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            clk_prev_q   <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            state_q      <= StIdle;
            bitcnt_q     <= 3'd0;
            shreg_q      <= 8'h00;
            par_ok_q     <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            frame_err_q  <= 1'b0;
            tmo_q        <= '0;
        end else begin
            clk_s1_q     <= ps2_clk_i;
            clk_s2_q     <= clk_s1_q;
            clk_prev_q   <= clk_s2_q;
            dat_s1_q     <= ps2_dat_i;
            dat_s2_q     <= dat_s1_q;
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            par_ok_q     <= par_ok_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            frame_err_q  <= frame_err_d;
            tmo_q        <= tmo_d;
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_control_decoder.sv
// PS/2 keyboard front end for the ship: decodes E0/F0 prefixes and scan codes
// into level-held control flags plus a shoot pulse per space make.
module ps2_control_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         PS2_CLK,
    input  logic                         PS2_DAT,
    input  logic                         controller_type,
    ps2_control_decoder_if.master        byte_if,
    output logic                         shoot,
    output logic                         forward,
    output logic                         rotate_right,
    output logic                         rotate_left,
    output logic                         shoot_pulse
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    ps2_rx_frame #(
        .Timeout (TIMEOUT)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk_i    (PS2_CLK),
        .ps2_dat_i    (PS2_DAT),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .frame_err_o  (frame_err)
    );

    assign byte_if.byte_valid = byte_valid;
    assign byte_if.byte_data  = byte_data;
    assign byte_if.frame_err  = frame_err;

    logic ext_q, ext_d, brk_q, brk_d, ct_q, ct_d;
    logic shoot_q, shoot_d, fwd_q, fwd_d, right_q, right_d, left_q, left_d;
    logic pulse_q, pulse_d;
    logic make;
    key_e key;

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        ct_d    = controller_type;
        shoot_d = shoot_q;
        fwd_d   = fwd_q;
        right_d = right_q;
        left_d  = left_q;
        pulse_d = 1'b0;
        make    = 1'b0;
        key     = KeyNone;

        if (byte_valid) begin
            case (byte_data)
                SC_EXT:   ext_d = 1'b1;
                SC_BRK:   brk_d = 1'b1;
                SC_PAUSE: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
                default: begin
                    make = ~brk_q;
                    key  = map_key(ct_q, ext_q, byte_data);
                    case (key)
                        KeyShoot: begin
                            shoot_d = make;
                            pulse_d = make;
                        end
                        KeyForward: fwd_d   = make;
                        KeyRight:   right_d = make;
                        KeyLeft:    left_d  = make;
                        default:    ;
                    endcase
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end

        if (frame_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end

        // Switching layouts drops every held key so nothing sticks across the change.
        if (controller_type != ct_q) begin
            shoot_d = 1'b0;
            fwd_d   = 1'b0;
            right_d = 1'b0;
            left_d  = 1'b0;
            pulse_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            ct_q    <= 1'b0;
            shoot_q <= 1'b0;
            fwd_q   <= 1'b0;
            right_q <= 1'b0;
            left_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            ct_q    <= ct_d;
            shoot_q <= shoot_d;
            fwd_q   <= fwd_d;
            right_q <= right_d;
            left_q  <= left_d;
            pulse_q <= pulse_d;
        end
    end

    assign shoot        = shoot_q;
    assign forward      = fwd_q;
    assign rotate_right = right_q;
    assign rotate_left  = left_q;
    assign shoot_pulse  = pulse_q;

endmodule

// File: tb/tb_ps2_control_decoder.sv
// Directed bench for ps2_control_decoder: drives PS/2 frames on the pins and
// compares outputs against hand-computed values.
module tb_ps2_control_decoder;

    localparam int Half = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic PS2_CLK = 1'b1;
    logic PS2_DAT = 1'b1;
    logic controller_type = 1'b0;
    logic shoot, forward, rotate_right, rotate_left, shoot_pulse;

    ps2_control_decoder_if bif ();

    ps2_control_decoder #(
        .TIMEOUT (50000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .PS2_CLK         (PS2_CLK),
        .PS2_DAT         (PS2_DAT),
        .controller_type (controller_type),
        .byte_if         (bif),
        .shoot           (shoot),
        .forward         (forward),
        .rotate_right    (rotate_right),
        .rotate_left     (rotate_left),
        .shoot_pulse     (shoot_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int bv_cnt   = 0;
    int fe_cnt   = 0;
    int sp_cnt   = 0;

    always @(negedge clk) begin
        if (bif.byte_valid) bv_cnt++;
        if (bif.frame_err)  fe_cnt++;
        if (shoot_pulse)    sp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] flags();
        return {shoot, forward, rotate_right, rotate_left};
    endfunction

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        PS2_DAT = b;
        repeat (Half) @(negedge clk);
        PS2_CLK = 1'b0;
        repeat (Half) @(negedge clk);
        PS2_CLK = 1'b1;
    endtask

    // Start bit plus the first nbits data bits, then the line is left idle.
    task automatic send_partial(input logic [7:0] b, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    endtask

    // lat=1 checks byte_valid/forward cycle-by-cycle around the stop-bit fall.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic lat);
        logic fwd_p3;
        send_partial(b, 8);
        ps2_bit((~^b) ^ bad_par);
        @(negedge clk);
        PS2_DAT = 1'b1;
        repeat (Half) @(negedge clk);
        PS2_CLK = 1'b0;
        if (lat) begin
            repeat (3) @(posedge clk);
            #1;
            check("lat_bv_p3", bif.byte_valid, 1);
            check("lat_data_p3", bif.byte_data, b);
            fwd_p3 = forward;
            check("lat_fwd_p3", fwd_p3, 0);
            @(posedge clk);
            #1;
            check("lat_bv_p4", bif.byte_valid, 0);
            check("lat_fwd_p4", forward, 1);
        end
        repeat (Half) @(negedge clk);
        PS2_CLK = 1'b1;
        repeat (2 * Half) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    int bv0, fe0, sp0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_flags", flags(), 4'b0000);
        check("rst_bv", bif.byte_valid, 0);
        check("rst_data", bif.byte_data, 8'h00);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 1: WASD forward make with latency probe, then break
        bv0 = bv_cnt;
        send_frame(8'h1D, 1'b0, 1'b1);
        check("t1_bv_cnt", bv_cnt - bv0, 1);
        check("t1_fwd_on", flags(), 4'b0100);
        send(8'hF0);
        send(8'h1D);
        check("t1_fwd_off", flags(), 4'b0000);

        // 2: arrows layout, extended right make and break; plain D ignored
        controller_type = 1'b1;
        repeat (4) @(negedge clk);
        send(8'hE0);
        send(8'h74);
        check("t2_right_on", flags(), 4'b0010);
        send(8'hE0);
        send(8'hF0);
        send(8'h74);
        check("t2_right_off", flags(), 4'b0000);
        bv0 = bv_cnt;
        send(8'h23);
        check("t2_d_bv", bv_cnt - bv0, 1);
        check("t2_d_ignored", flags(), 4'b0000);

        // 3: typematic space
        sp0 = sp_cnt;
        for (int i = 0; i < 3; i++) begin
            send(8'h29);
            check("t3_shoot_held", flags(), 4'b1000);
        end
        check("t3_pulses", sp_cnt - sp0, 3);
        send(8'hF0);
        send(8'h29);
        check("t3_shoot_off", flags(), 4'b0000);

        // 4: 0x1C has three ones, so parity 1 is the corrupt value
        bv0 = bv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h1C, 1'b1, 1'b0);
        check("t4_fe", fe_cnt - fe0, 1);
        check("t4_no_bv", bv_cnt - bv0, 0);
        check("t4_left_off", rotate_left, 0);
        send(8'hF0);
        check("t4_f0_data", bif.byte_data, 8'hF0);
        check("t4_f0_bv", bv_cnt - bv0, 1);
        sp0 = sp_cnt;
        send(8'h29);
        check("t4_break_nopulse", sp_cnt - sp0, 0);
        check("t4_flags", flags(), 4'b0000);

        // 5: pending F0 then a stalled frame; timeout must drop the prefix
        controller_type = 1'b0;
        repeat (4) @(negedge clk);
        send(8'hF0);
        fe0 = fe_cnt;
        send_partial(8'h1D, 4);
        repeat (49900) @(negedge clk);
        check("t5_no_early_fe", fe_cnt - fe0, 0);
        for (int i = 0; i < 400 && fe_cnt == fe0; i++) @(negedge clk);
        check("t5_tmo_fe", fe_cnt - fe0, 1);
        send(8'h23);
        check("t5_right_on", flags(), 4'b0010);

        // 6: layout change clears held keys, then reset mid-frame
        send(8'h1D);
        send(8'h1C);
        check("t6_held", flags(), 4'b0111);
        @(negedge clk);
        controller_type = 1'b1;
        @(posedge clk);
        #1;
        check("t6_ct_clear", flags(), 4'b0000);
        repeat (4) @(negedge clk);
        send_partial(8'h55, 3);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_rst_out", {bif.byte_valid, bif.frame_err, shoot_pulse, flags()}, 7'b0);
        check("t6_rst_data", bif.byte_data, 8'h00);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        send(8'h29);
        check("t6_fresh_data", bif.byte_data, 8'h29);
        check("t6_fresh_shoot", flags(), 4'b1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
